// File: rtl/fx_mac_lanes.sv
// fx_mac_lanes: LANES parallel signed fixed-point dot-product engines.
// Each lane does the following:
//   - multiplies win*din on every accepted beat;
//   - accumulates k_len products;
//   - rounds round-half-to-even;
//   - saturates back to the WIDTH/FRACTION operand format.
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   k_len            dot-product length, sampled on the first beat (0->1, >KMAX->KMAX)
//   in_vld/in_rdy    operand beat handshake; win/din packed lane i at [i*WIDTH +: WIDTH]
//   out_vld/out_rdy  result handshake; acc_o/sat_o held while out_vld && !out_rdy
//   acc_o, sat_o     rounded/saturated results and per-lane saturation flags

// Per-lane datapath: product register, accumulator, round/saturate output register.
module fx_mac_lane #(
   parameter int WIDTH    = 8,
   parameter int FRACTION = 4,
   parameter int WIDTH_A  = 23
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,     // first beat of a new dot product
   input  logic                    beat,      // accepted beat
   input  logic                    mult_vld,  // mult_q holds an unconsumed product
   input  logic                    round_en,
   input  logic signed [WIDTH-1:0] w,
   input  logic signed [WIDTH-1:0] d,
   output logic        [WIDTH-1:0] res,
   output logic                    sat
);
   localparam logic signed [WIDTH_A:0]   QMAX  = (WIDTH_A+1)'((1 << (WIDTH-1)) - 1);
   localparam logic signed [WIDTH_A:0]   QMIN  = ~QMAX;
   // Bits below the guard bit; empty when FRACTION == 1, so sticky is 0 then.
   localparam logic        [WIDTH_A-1:0] SMASK = WIDTH_A'((1 << (FRACTION-1)) - 1);

   logic signed [2*WIDTH-1:0] mult_q, mult_d;
   logic signed [WIDTH_A-1:0] acc_q, acc_d;
   logic        [WIDTH-1:0]   res_q, res_d;
   logic                      sat_q, sat_d;
   logic                      guard, sticky, lsb, up;
   logic signed [WIDTH_A:0]   r, q;

   always_comb begin
      mult_d = beat ? (2*WIDTH)'(w) * (2*WIDTH)'(d) : mult_q;

      acc_d = acc_q;
      if (start)
         acc_d = '0;
      else if (mult_vld)
         acc_d = acc_q + {{(WIDTH_A-2*WIDTH){mult_q[2*WIDTH-1]}}, mult_q};

      guard  = acc_q[FRACTION-1];
      sticky = |(acc_q & SMASK);
      lsb    = acc_q[FRACTION];
      up     = guard & (sticky | lsb);
      // One extra bit so the round-up increment can never wrap.
      r      = {acc_q[WIDTH_A-1], acc_q} + ((WIDTH_A+1)'(up) << FRACTION);
      q      = r >>> FRACTION;

      res_d = res_q;
      sat_d = sat_q;
      if (round_en) begin
         if (q > QMAX) begin
            res_d = {1'b0, {(WIDTH-1){1'b1}}};
            sat_d = 1'b1;
         end else if (q < QMIN) begin
            res_d = {1'b1, {(WIDTH-1){1'b0}}};
            sat_d = 1'b1;
         end else begin
            res_d = q[WIDTH-1:0];
            sat_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         mult_q <= '0;
         acc_q  <= '0;
         res_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         mult_q <= mult_d;
         acc_q  <= acc_d;
         res_q  <= res_d;
         sat_q  <= sat_d;
      end
   end

   assign res = res_q;
   assign sat = sat_q;
endmodule

module fx_mac_lanes #(
   parameter int WIDTH    = 8,
   parameter int FRACTION = 4,
   parameter int LANES    = 4,
   parameter int KMAX     = 16,
   parameter int WK       = $clog2(KMAX+1),
   parameter int WIDTH_A  = WK + 2*WIDTH + 2
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [WK-1:0]          k_len,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [LANES*WIDTH-1:0] win,
   input  logic [LANES*WIDTH-1:0] din,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [LANES*WIDTH-1:0] acc_o,
   output logic [LANES-1:0]       sat_o
);
   typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, ROUND, OUT} state_t;

   state_t         state_q, state_d;
   logic [WK-1:0]  cnt_q, cnt_d, klat_q, klat_d, k_eff;
   logic           mult_vld_q, mult_vld_d;
   logic           beat, start, round_en;

   always_comb begin
      k_eff = k_len;
      if (k_len == '0)
         k_eff = WK'(1);
      else if (k_len > WK'(KMAX))
         k_eff = WK'(KMAX);

      in_rdy   = rstn & ((state_q == IDLE) | (state_q == ACCUM));
      out_vld  = (state_q == OUT);
      beat     = in_vld & in_rdy;
      start    = beat & (state_q == IDLE);
      round_en = (state_q == ROUND);

      state_d    = state_q;
      cnt_d      = cnt_q;
      klat_d     = klat_q;
      mult_vld_d = beat;
      case (state_q)
         IDLE:
            if (beat) begin
               klat_d  = k_eff;
               cnt_d   = WK'(1);
               state_d = (k_eff == WK'(1)) ? FLUSH : ACCUM;
            end
         ACCUM:
            if (beat) begin
               cnt_d = cnt_q + WK'(1);
               if (cnt_d == klat_q)
                  state_d = FLUSH;
            end
         FLUSH:   state_d = ROUND;   // last registered products drain into acc
         ROUND:   state_d = OUT;
         OUT:     if (out_rdy) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         klat_q     <= '0;
         mult_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         klat_q     <= klat_d;
         mult_vld_q <= mult_vld_d;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fx_mac_lane #(
         .WIDTH    (WIDTH),
         .FRACTION (FRACTION),
         .WIDTH_A  (WIDTH_A)
      ) u_lane (
         .clk      (clk),
         .rstn     (rstn),
         .start    (start),
         .beat     (beat),
         .mult_vld (mult_vld_q),
         .round_en (round_en),
         .w        (win[i*WIDTH +: WIDTH]),
         .d        (din[i*WIDTH +: WIDTH]),
         .res      (acc_o[i*WIDTH +: WIDTH]),
         .sat      (sat_o[i])
      );
   end
endmodule

// File: tb/tb_fx_mac_lanes.sv
module tb_fx_mac_lanes;
   localparam int W    = 8;
   localparam int F    = 4;
   localparam int L    = 4;
   localparam int KMAX = 16;
   localparam int WK   = $clog2(KMAX+1);

   logic           clk, rstn, in_vld, in_rdy, out_vld, out_rdy;
   logic [WK-1:0]  k_len;
   logic [L*W-1:0] win, din, acc_o;
   logic [L-1:0]   sat_o;

   int passes = 0;
   int total  = 0;

   logic signed [W-1:0] wv [KMAX][L];
   logic signed [W-1:0] dv [KMAX][L];

   fx_mac_lanes #(.WIDTH(W), .FRACTION(F), .LANES(L), .KMAX(KMAX)) dut (
      .clk(clk), .rstn(rstn), .k_len(k_len), .in_vld(in_vld), .in_rdy(in_rdy),
      .win(win), .din(din), .out_vld(out_vld), .out_rdy(out_rdy),
      .acc_o(acc_o), .sat_o(sat_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Exact sum -> nearest multiple of 2^F (ties to even quotient), then clamp.
   function automatic logic [W:0] ref_lane(input longint s);
      longint q, rem;
      q   = s >>> F;
      rem = s - (q <<< F);
      if (rem > (1 << (F-1)) || (rem == (1 << (F-1)) && q[0])) q++;
      if (q > 127)  return {1'b1, 8'h7F};
      if (q < -128) return {1'b1, 8'h80};
      return {1'b0, q[7:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rand(input int n);
      for (int b = 0; b < n; b++)
         for (int l = 0; l < L; l++) begin
            wv[b][l] = W'($urandom);
            dv[b][l] = W'($urandom);
         end
   endtask

   task automatic fill_zero();
      for (int b = 0; b < KMAX; b++)
         for (int l = 0; l < L; l++) begin
            wv[b][l] = '0;
            dv[b][l] = '0;
         end
   endtask

   // Run one dot product with optional input gaps and an out_rdy hold,
   // checking handshake timing and every lane against the reference model.
   task automatic do_dot(input int klen, input int maxgap, input int hold, input string tag);
      int             eff;
      longint         s [L];
      logic [L*W-1:0] exp_acc;
      logic [L-1:0]   exp_sat;
      logic [W:0]     rl;
      eff = (klen == 0) ? 1 : (klen > KMAX) ? KMAX : klen;
      for (int l = 0; l < L; l++) s[l] = 0;
      for (int b = 0; b < eff; b++) begin
         int g;
         g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
         for (int c = 0; c < g; c++) begin
            in_vld = 1'b0;
            win = L*W'($urandom);
            din = L*W'($urandom);
            tick();
         end
         k_len  = (b == 0) ? WK'(klen) : WK'($urandom_range(31, 0));
         in_vld = 1'b1;
         for (int l = 0; l < L; l++) begin
            win[l*W +: W] = wv[b][l];
            din[l*W +: W] = dv[b][l];
            s[l] += longint'(wv[b][l]) * longint'(dv[b][l]);
         end
         chk({tag, " in_rdy_beat"}, 64'(in_rdy), 64'd1);
         tick();
      end
      // Junk offered while busy must be ignored.
      in_vld = 1'b1;
      win = L*W'($urandom);
      din = L*W'($urandom);
      chk({tag, " flush_in_rdy"}, 64'(in_rdy), 64'd0);
      chk({tag, " flush_out_vld"}, 64'(out_vld), 64'd0);
      tick();
      chk({tag, " round_out_vld"}, 64'(out_vld), 64'd0);
      tick();
      in_vld = 1'b0;
      chk({tag, " out_vld"}, 64'(out_vld), 64'd1);
      for (int l = 0; l < L; l++) begin
         rl = ref_lane(s[l]);
         exp_acc[l*W +: W] = rl[W-1:0];
         exp_sat[l]        = rl[W];
      end
      chk({tag, " acc_o"}, 64'(acc_o), 64'(exp_acc));
      chk({tag, " sat_o"}, 64'(sat_o), 64'(exp_sat));
      for (int h = 0; h < hold; h++) begin
         out_rdy = 1'b0;
         tick();
         chk({tag, " hold_out_vld"}, 64'(out_vld), 64'd1);
         chk({tag, " hold_acc_o"}, 64'(acc_o), 64'(exp_acc));
         chk({tag, " hold_in_rdy"}, 64'(in_rdy), 64'd0);
      end
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      chk({tag, " done_out_vld"}, 64'(out_vld), 64'd0);
      chk({tag, " done_in_rdy"}, 64'(in_rdy), 64'd1);
   endtask

   initial begin
      bit seen;
      rstn = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; k_len = '0; win = '0; din = '0;
      tick();
      tick();
      chk("rst in_rdy", 64'(in_rdy), 64'd0);
      chk("rst out_vld", 64'(out_vld), 64'd0);
      chk("rst acc_o", 64'(acc_o), 64'd0);
      chk("rst sat_o", 64'(sat_o), 64'd0);
      rstn = 1'b1;
      #1;
      chk("rel in_rdy", 64'(in_rdy), 64'd1);

      // 2.0*... lane0: 1.0*2.0 + 0.5*1.0 = 2.5
      fill_zero();
      wv[0][0] = 8'h10; dv[0][0] = 8'h20;
      wv[1][0] = 8'h08; dv[1][0] = 8'h10;
      do_dot(2, 0, 0, "basic");
      chk("basic lane0 const", 64'(acc_o[7:0]), 64'h28);

      // Ties and near-ties.
      fill_zero();
      wv[0][0] = 8'h01; dv[0][0] = 8'h08;
      wv[0][1] = 8'h01; dv[0][1] = 8'h18;
      wv[0][2] = 8'h01; dv[0][2] = 8'h09;
      wv[0][3] = 8'hFF; dv[0][3] = 8'h08;
      do_dot(1, 0, 0, "round");
      chk("round const", 64'(acc_o), 64'h01_02_00_00 & 64'h00_01_02_00 | 64'h0001_0200);

      // Saturation in both directions.
      fill_zero();
      for (int b = 0; b < 2; b++) begin
         wv[b][0] = 8'h7F; dv[b][0] = 8'h7F;
         wv[b][1] = 8'h80; dv[b][1] = 8'h7F;
      end
      wv[0][2] = 8'h80; dv[0][2] = 8'h80;
      do_dot(2, 0, 0, "sat");
      chk("sat flags const", 64'(sat_o[2:0]), 64'h7);

      // Gaps between beats must not change the sum.
      fill_rand(4);
      do_dot(4, 0, 0, "k4_nogap");
      do_dot(4, 3, 0, "k4_gap");

      // Downstream backpressure, then back-to-back next dot product.
      fill_rand(3);
      do_dot(3, 0, 5, "bp");
      do_dot(3, 0, 0, "bp_next");

      fill_rand(1);
      do_dot(0, 0, 0, "k0");

      for (int b = 0; b < KMAX; b++)
         for (int l = 0; l < L; l++) begin
            wv[b][l] = 8'h7F; dv[b][l] = 8'h7F;
         end
      do_dot(KMAX, 0, 0, "kmax");
      chk("kmax const", 64'({sat_o, acc_o}), 64'hF_7F7F7F7F);

      fill_rand(KMAX);
      do_dot(31, 1, 0, "k31");

      // Abort mid-accumulation.
      k_len = WK'(8);
      for (int b = 0; b < 3; b++) begin
         in_vld = 1'b1;
         win = L*W'($urandom);
         din = L*W'($urandom);
         tick();
      end
      in_vld = 1'b0;
      rstn   = 1'b0;
      tick();
      chk("abort rst in_rdy", 64'(in_rdy), 64'd0);
      chk("abort rst out_vld", 64'(out_vld), 64'd0);
      rstn = 1'b1;
      #1;
      chk("abort rel in_rdy", 64'(in_rdy), 64'd1);
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         seen |= out_vld;
      end
      chk("abort no out_vld", 64'(seen), 64'd0);
      fill_zero();
      for (int l = 0; l < L; l++) begin
         wv[0][l] = 8'h10; dv[0][l] = 8'h10;
      end
      do_dot(1, 0, 0, "after_abort");
      chk("after_abort const", 64'(acc_o), 64'h10101010);

      // Random mix of lengths, gaps and holds.
      for (int t = 0; t < 20; t++) begin
         fill_rand(KMAX);
         do_dot(int'($urandom_range(31, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), "rand");
      end

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
